// File: rtl/regfile_decoded_np_pkg.sv
// Shared definitions for the decoded register file: default geometry,
// parameter encodings and the address-width helper.
package regfile_decoded_np_pkg;

    localparam int unsigned RF_DEFAULT_WIDTH = 32;
    localparam int unsigned RF_DEFAULT_NREGS = 32;
    localparam int unsigned RF_DEFAULT_NRD   = 2;
    localparam int unsigned RF_MAX_NRD       = 4;

    localparam bit RF_ZERO_REG_OFF = 1'b0;
    localparam bit RF_ZERO_REG_ON  = 1'b1;
    localparam bit RF_BYPASS_OFF   = 1'b0;
    localparam bit RF_BYPASS_ON    = 1'b1;

    localparam int unsigned RF_COUNT_W   = 16;
    localparam logic [15:0] RF_COUNT_MAX = 16'hFFFF;

    // Smallest r with 2**r >= n; usable in constant expressions.
    function automatic int unsigned rf_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_decoded_np_onehot_decoder.sv
// Generic one-hot decoder: z[i] is set only when en is high and x equals i.
module onehot_decoder #(
    parameter  int unsigned AW = 5,
    localparam int unsigned N  = 1 << AW
) (
    input  logic [AW-1:0] x,
    input  logic          en,
    output logic [N-1:0]  z
);

    // Gating by en first keeps an unknown x from reaching z while idle.
    always_comb begin
        z = '0;
        for (int unsigned i = 0; i < N; i++) begin
            z[i] = en && (x == AW'(i));
        end
    end

endmodule

// File: rtl/regfile_decoded_np.sv
// Parametrised register file: one synchronous write port with internal one-hot
// decode, NRD combinational read ports, optional bypass and hardwired zero register.
module regfile_decoded_np
    import regfile_decoded_np_pkg::*;
#(
    parameter  int unsigned WIDTH    = RF_DEFAULT_WIDTH,
    parameter  int unsigned NREGS    = RF_DEFAULT_NREGS,
    parameter  int unsigned NRD      = RF_DEFAULT_NRD,
    parameter  bit          ZERO_REG = RF_ZERO_REG_ON,
    parameter  bit          BYPASS   = RF_BYPASS_ON,
    localparam int unsigned AW       = rf_clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*WIDTH-1:0]  rd_data,
    output logic [NREGS-1:0]      wr_onehot,
    output logic [RF_COUNT_W-1:0] wr_count
);

    if ((NREGS < 2) || (NREGS != (1 << AW))) begin : g_bad_nregs
        $error("regfile_decoded_np: NREGS must be a power of two >= 2");
    end
    if ((NRD < 1) || (NRD > RF_MAX_NRD)) begin : g_bad_nrd
        $error("regfile_decoded_np: NRD must be in 1..4");
    end

    logic [NREGS-1:0]      dec;
    logic [NREGS-1:0]      wr_mask;
    logic [WIDTH-1:0]      rf [NREGS];
    logic [NREGS-1:0]      wr_onehot_q;
    logic [RF_COUNT_W-1:0] wr_count_q;
    logic [RF_COUNT_W-1:0] wr_count_d;

    onehot_decoder #(.AW(AW)) u_dec (
        .x  (wr_addr),
        .en (wr_en),
        .z  (dec)
    );

    // Writes to a hardwired r0 are dropped here so they neither commit nor count.
    always_comb begin
        wr_mask = dec;
        if (ZERO_REG) begin
            wr_mask[0] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [WIDTH-1:0] reg_q;
        if (ZERO_REG && (gi == 0)) begin : g_zero
            assign reg_q = '0;
        end else begin : g_flop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else if (wr_mask[gi]) begin
                    reg_q <= wr_data;
                end
            end
        end
        assign rf[gi] = reg_q;
    end

    // Priority: zero register, then same-cycle bypass, then stored value.
    for (genvar gp = 0; gp < NRD; gp++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        assign addr = rd_addr[gp*AW +: AW];
        always_comb begin
            data = rf[addr];
            if (BYPASS && wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
            end
        end
        assign rd_data[gp*WIDTH +: WIDTH] = data;
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if ((|wr_mask) && (wr_count_q != RF_COUNT_MAX)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_onehot_q <= '0;
            wr_count_q  <= '0;
        end else begin
            wr_onehot_q <= wr_mask;
            wr_count_q  <= wr_count_d;
        end
    end

    assign wr_onehot = wr_onehot_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_decoded_np.sv
// Directed bench for regfile_decoded_np: default build, a no-bypass build
// sharing its stimulus, and a small 8x16 three-port build.
module tb_regfile_decoded_np;

    logic clk;
    logic rst_n;

    // Default build (u_a) and BYPASS=0 build (u_b) share inputs.
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic [9:0]  a_ra;
    logic [63:0] a_rd, b_rd;
    logic [31:0] a_oh, b_oh;
    logic [15:0] a_cnt, b_cnt;

    // NREGS=8, WIDTH=16, NRD=3 build.
    logic        c_we;
    logic [2:0]  c_wa;
    logic [15:0] c_wd;
    logic [8:0]  c_ra;
    logic [47:0] c_rd;
    logic [7:0]  c_oh;
    logic [15:0] c_cnt;

    int n_cmp;
    int n_bad;

    regfile_decoded_np u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
        .rd_addr(a_ra), .rd_data(a_rd), .wr_onehot(a_oh), .wr_count(a_cnt)
    );

    regfile_decoded_np #(.BYPASS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
        .rd_addr(a_ra), .rd_data(b_rd), .wr_onehot(b_oh), .wr_count(b_cnt)
    );

    regfile_decoded_np #(.WIDTH(16), .NREGS(8), .NRD(3)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_we), .wr_addr(c_wa), .wr_data(c_wd),
        .rd_addr(c_ra), .rd_data(c_rd), .wr_onehot(c_oh), .wr_count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
        logic [31:0] eoh;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [31:0] sweep_exp(input int j);
        return (j == 0) ? 32'd0 : 32'(j + 1);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //                we    wa     wd             r0     r1     a.p0           a.p1           b.p0           b.p1           onehot         count
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,         16'd0};
        tbl[1] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_0020, 16'd1};
        tbl[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,         16'd1};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,         16'd1};
        tbl[4] = '{1'b1, 5'd7,  32'hA5A5,     5'd7,  5'd5,  32'hA5A5,     32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,         16'd1};
        tbl[5] = '{1'b1, 5'd7,  32'h5A5A,     5'd7,  5'd3,  32'h5A5A,     32'h0,        32'hA5A5,     32'h0,        32'h0000_0080, 16'd2};
        tbl[6] = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd31, 32'h5A5A,     32'h0,        32'h5A5A,     32'h0,        32'h0000_0080, 16'd3};
        tbl[7] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd7,  32'h0,        32'h5A5A,     32'h0,        32'h5A5A,     32'h0,         16'd3};
        tbl[8] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,         16'd3};
        tbl[9] = '{1'b1, 5'd3,  32'h3333,     5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 32'h8000_0000, 16'd4};

        rst_n = 1'b0;
        a_we = 1'b0; a_wa = '0; a_wd = '0; a_ra = '0;
        c_we = 1'b0; c_wa = '0; c_wd = '0; c_ra = '0;

        #2;
        chk("reset a.rd", a_rd, 64'h0);
        chk("reset a.onehot", 64'(a_oh), 64'h0);
        chk("reset a.count", 64'(a_cnt), 64'h0);
        chk("reset c.rd", 64'(c_rd), 64'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Small build: write r5, then same-cycle bypass of r7 on port 0.
        @(negedge clk);
        c_we = 1'b1; c_wa = 3'd5; c_wd = 16'hBEEF; c_ra = {3'd5, 3'd5, 3'd5};
        @(negedge clk);
        c_we = 1'b1; c_wa = 3'd7; c_wd = 16'hA5A5; c_ra = {3'd0, 3'd5, 3'd7};
        #1;
        chk("c bypass p0", 64'(c_rd[15:0]), 64'hA5A5);
        chk("c r5 p1", 64'(c_rd[31:16]), 64'hBEEF);
        chk("c r0 p2", 64'(c_rd[47:32]), 64'h0);
        chk("c onehot r5", 64'(c_oh), 64'h20);
        chk("c count 1", 64'(c_cnt), 64'd1);
        @(negedge clk);
        c_we = 1'b0; c_ra = {3'd5, 3'd5, 3'd5};
        #1;
        chk("c r5 all ports", 64'(c_rd), 64'hBEEF_BEEF_BEEF);
        chk("c onehot r7", 64'(c_oh), 64'h80);
        chk("c count 2", 64'(c_cnt), 64'd2);
        c_ra = {3'd5, 3'd0, 3'd7};
        #1;
        chk("c r7 stored", 64'(c_rd), 64'hBEEF_0000_A5A5);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a_we = tbl[k].we; a_wa = tbl[k].wa; a_wd = tbl[k].wd;
            a_ra = {tbl[k].r1, tbl[k].r0};
            #1;
            chk($sformatf("tbl%0d a.p0", k), 64'(a_rd[31:0]), 64'(tbl[k].ea0));
            chk($sformatf("tbl%0d a.p1", k), 64'(a_rd[63:32]), 64'(tbl[k].ea1));
            chk($sformatf("tbl%0d b.p0", k), 64'(b_rd[31:0]), 64'(tbl[k].eb0));
            chk($sformatf("tbl%0d b.p1", k), 64'(b_rd[63:32]), 64'(tbl[k].eb1));
            chk($sformatf("tbl%0d onehot", k), 64'(a_oh), 64'(tbl[k].eoh));
            chk($sformatf("tbl%0d b.onehot", k), 64'(b_oh), 64'(tbl[k].eoh));
            chk($sformatf("tbl%0d count", k), 64'(a_cnt), 64'(tbl[k].ecnt));
        end

        // Asynchronous reset mid-operation, with a concurrent write that must be lost.
        @(negedge clk);
        rst_n = 1'b0;
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h1111; a_ra = {5'd31, 5'd5};
        #1;
        chk("async rst a.rd", a_rd, 64'h0);
        chk("async rst b.rd", b_rd, 64'h0);
        chk("async rst onehot", 64'(a_oh), 64'h0);
        chk("async rst count", 64'(a_cnt), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_we = 1'b0; a_ra = {5'd3, 5'd9};
        #1;
        chk("rst wins write", a_rd, 64'h0);
        chk("rst onehot after", 64'(a_oh), 64'h0);

        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            a_we = 1'b1; a_wa = 5'(i); a_wd = 32'(i + 1);
            @(posedge clk);
            #1;
            chk($sformatf("sweep onehot r%0d", i), 64'(a_oh), 64'(32'h1 << i));
        end
        @(negedge clk);
        a_we = 1'b0;
        #1;
        chk("sweep count", 64'(a_cnt), 64'd31);
        for (int i = 0; i < 32; i++) begin
            a_ra = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("sweep rd r%0d", i), 64'(a_rd[31:0]), 64'(sweep_exp(i)));
            chk($sformatf("sweep rd r%0d", 31 - i), 64'(a_rd[63:32]), 64'(sweep_exp(31 - i)));
        end

        // 31 writes so far; 65503 more reach 16'hFFFE, 3 more must stop at 16'hFFFF.
        for (int n = 0; n < 65503; n++) begin
            @(negedge clk);
            a_we = 1'b1; a_wa = 5'd1; a_wd = 32'(n);
        end
        @(negedge clk);
        a_we = 1'b0;
        #1;
        chk("count below sat", 64'(a_cnt), 64'hFFFE);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            a_we = 1'b1; a_wa = 5'd2; a_wd = 32'(n);
        end
        @(negedge clk);
        a_we = 1'b0;
        #1;
        chk("count saturated", 64'(a_cnt), 64'hFFFF);
        chk("b count saturated", 64'(b_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
